icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Miss/refill and flush sequencer for the instruction fetch stage's direct-mapped instruction cache.
- Watches the cache hit result for the current PC and stalls the PC on a miss.
- On a miss, fetches the 64-bit line (4 x 16-bit instructions) from instruction memory over a req/ready handshake and writes it into the cache.
- Also performs a multi-cycle invalidate sweep of every cache line on request.

Parameters:
- INDEX_BITS, 3, cache index width; 2^INDEX_BITS lines; tag width TAG_W = 16 - INDEX_BITS - 2.
- CNT_WIDTH, 16, width of saturating miss counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- fetch_valid  in  1  PC is presenting a valid fetch address.
- fetch_addr  in  16  instruction (halfword) address; [1:0] = word-in-line, [INDEX_BITS+1:2] = index, [15:INDEX_BITS+2] = tag.
- cache_hit  in  1  cache tag-compare result for fetch_addr, same cycle.
- flush_req  in  1  single-cycle request to invalidate the whole cache.
- mem_req  out  1  line-read request to instruction memory.
- mem_addr  out  16  line-aligned address, [1:0] = 0.
- mem_ready  in  1  memory accepts the request; mem_data is valid this cycle.
- mem_data  in  64  returned line.
- fill_we  out  1  cache line write strobe; also sets the line's valid bit.
- fill_index  out  INDEX_BITS  line being written.
- fill_tag  out  TAG_W  tag being written.
- fill_data  out  64  line data being written.
- inval_we  out  1  clear the valid bit at inval_index.
- inval_index  out  INDEX_BITS  line being invalidated.
- stall  out  1  freeze PC; fetch output is not valid.
- flush_done  out  1  one-cycle pulse when the sweep completes.
- miss_count  out  CNT_WIDTH  number of misses taken, saturating.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE; sweep counter, latched address/data, pending-flush flag and miss_count all cleared.
  - Every output is 0, including stall, which is 0 in IDLE while fetch_valid = 0.
- States: IDLE, FLUSH, MISS_REQ, FILL.
- IDLE:
  - stall = fetch_valid & ~cache_hit (combinational, so the PC holds in the same cycle). All other strobes are 0.
  - Priority 1: flush_req or the pending-flush flag -> FLUSH; counter = 0; pending-flush flag cleared. A simultaneous miss is not latched; it is re-detected after the flush.
  - Priority 2: fetch_valid & ~cache_hit -> MISS_REQ. Latch {fetch_addr[15:2], 2'b00}. miss_count += 1, holding at all-ones.
- FLUSH:
  - stall = 1, inval_we = 1, inval_index = counter; counter increments each cycle.
  - When counter = 2^INDEX_BITS - 1: go to IDLE and assert flush_done for that cycle.
  - The sweep lasts exactly 2^INDEX_BITS cycles. flush_req arriving during FLUSH is ignored.
- MISS_REQ:
  - stall = 1, mem_req = 1, mem_addr = latched line address, held stable until mem_ready.
  - No timeout; the controller waits indefinitely.
  - On mem_ready: capture mem_data -> FILL. mem_req drops the cycle after mem_ready.
- FILL:
  - stall = 1 and fill_we = 1 for exactly one cycle.
  - fill_index and fill_tag come from the latched address; fill_data comes from the captured line.
  - Then -> IDLE, where the same address is looked up again and hits.
- flush_req during MISS_REQ or FILL: sets the pending-flush flag. The refill completes first, then the flush runs from IDLE before any new miss.
- Miss penalty with mem_ready on the first request cycle: stall is high for 3 cycles (IDLE detect, MISS_REQ, FILL); the instruction is valid on the 4th cycle.
- Never assert fill_we and inval_we in the same cycle.
- Mid-operation reset (MISS_REQ, FILL or FLUSH): abandon at the next edge and go to IDLE; mem_req, fill_we and inval_we drop in that cycle. No partial line is written after reset.

Test Plan:
- Hit path: reset, fetch_valid = 1, cache_hit = 1, addr 0x0010 for 5 cycles -> stall = 0 throughout, mem_req never asserted, miss_count = 0.
- Miss/refill: addr 0x1236, cache_hit = 0, mem_ready 4 cycles after mem_req rises, mem_data = 0xAAAA_BBBB_CCCC_DDDD -> mem_addr = 0x1234 held stable; then fill_we for 1 cycle with fill_index = 5, fill_tag = 0x091, fill_data equal to mem_data; miss_count = 1; stall low once cache_hit returns to 1.
- Flush sweep (INDEX_BITS = 3): pulse flush_req in IDLE -> inval_we for 8 consecutive cycles with inval_index 0..7; flush_done on the 8th; stall = 1 for all 8 cycles.
- Flush during refill: flush_req while in MISS_REQ -> refill completes (fill_we), then the 8-cycle sweep starts from IDLE with no second mem_req in between.
- Reset mid-refill: rst_n = 0 while mem_req = 1 -> next cycle mem_req = 0, stall = 0, miss_count = 0; no fill_we ever asserted.
- Saturation: force 2^16 + 3 misses (or set CNT_WIDTH = 2 and force 6 misses) -> miss_count holds at all-ones.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// icache_refill_ctrl : miss/refill and whole-cache flush sequencer for a
// direct-mapped instruction cache.               Rev 1.0
// ============================================================================
module icache_refill_ctrl #(
  parameter int INDEX_BITS = 3,
  parameter int CNT_WIDTH  = 16,
  localparam int TAG_W     = 16 - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_valid,
  input  logic [15:0]           fetch_addr,
  input  logic                  cache_hit,
  input  logic                  flush_req,
  output logic                  mem_req,
  output logic [15:0]           mem_addr,
  input  logic                  mem_ready,
  input  logic [63:0]           mem_data,
  output logic                  fill_we,
  output logic [INDEX_BITS-1:0] fill_index,
  output logic [TAG_W-1:0]      fill_tag,
  output logic [63:0]           fill_data,
  output logic                  inval_we,
  output logic [INDEX_BITS-1:0] inval_index,
  output logic                  stall,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    MISS_REQ = 2'd2,
    FILL     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] cnt_q, cnt_d;
  logic [13:0]           line_q, line_d;
  logic [63:0]           data_q, data_d;
  logic                  pend_q, pend_d;
  logic [CNT_WIDTH-1:0]  miss_q, miss_d;
  logic                  miss_det;
  logic                  unused_word_bits;

  // Word-in-line bits never matter: a refill always fetches the whole line.
  assign unused_word_bits = ^fetch_addr[1:0];
  assign miss_det         = fetch_valid & ~cache_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    data_d  = data_q;
    pend_d  = pend_q;
    miss_d  = miss_q;
    case (state_q)
      IDLE: begin
        if (flush_req || pend_q) begin
          state_d = FLUSH;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (miss_det) begin
          state_d = MISS_REQ;
          line_d  = fetch_addr[15:2];
          if (miss_q != '1) miss_d = miss_q + 1'b1;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      MISS_REQ: begin
        if (flush_req) pend_d = 1'b1;
        if (mem_ready) begin
          data_d  = mem_data;
          state_d = FILL;
        end
      end
      FILL: begin
        if (flush_req) pend_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      miss_q  <= miss_d;
    end
  end

  // Strobes decode straight from the registered state; only the IDLE stall
  // term is combinational so the PC freezes in the detect cycle.
  assign mem_req     = (state_q == MISS_REQ);
  assign mem_addr    = {line_q, 2'b00};
  assign fill_we     = (state_q == FILL);
  assign fill_index  = line_q[INDEX_BITS-1:0];
  assign fill_tag    = line_q[13:INDEX_BITS];
  assign fill_data   = data_q;
  assign inval_we    = (state_q == FLUSH);
  assign inval_index = cnt_q;
  assign flush_done  = (state_q == FLUSH) && (cnt_q == '1);
  assign stall       = (state_q != IDLE) | miss_det;
  assign miss_count  = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// Scoreboard bench for icache_refill_ctrl (INDEX_BITS = 3, CNT_WIDTH = 2).
module tb_icache_refill_ctrl;

  typedef struct {
    logic [2:0]  idx;
    logic [10:0] tag;
    logic [63:0] data;
  } fill_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [15:0] fetch_addr;
  logic        cache_hit;
  logic        flush_req;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [63:0] mem_data;
  logic        fill_we;
  logic [2:0]  fill_index;
  logic [10:0] fill_tag;
  logic [63:0] fill_data;
  logic        inval_we;
  logic [2:0]  inval_index;
  logic        stall;
  logic        flush_done;
  logic [1:0]  miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_addr_q[$];
  fill_t       exp_fill_q[$];
  logic [2:0]  exp_inval_q[$];
  logic        mon_en = 1'b0;
  logic        prev_req = 1'b0;
  logic [15:0] cur_addr = '0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(.INDEX_BITS(3), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .cache_hit(cache_hit), .flush_req(flush_req), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag),
    .fill_data(fill_data), .inval_we(inval_we), .inval_index(inval_index),
    .stall(stall), .flush_done(flush_done), .miss_count(miss_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mem_req();
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    if (i == 20) check_eq("memreq_timeout", 1, 0);
  endtask

  // Output monitor: pops expectations whenever the DUT produces a transaction.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fill_we || inval_we) check_eq("we_excl", 64'(fill_we & inval_we), 0);
      if (mem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) check_eq("memreq_unexp", 1, 0);
        else begin
          cur_addr = exp_addr_q.pop_front();
          check_eq("mem_addr", mem_addr, cur_addr);
        end
      end else if (mem_req) begin
        check_eq("mem_addr_hold", mem_addr, cur_addr);
      end
      prev_req = mem_req;
      if (fill_we) begin
        if (exp_fill_q.size() == 0) check_eq("fill_unexp", 1, 0);
        else begin
          fill_t f;
          f = exp_fill_q.pop_front();
          check_eq("fill_index", fill_index, f.idx);
          check_eq("fill_tag", fill_tag, f.tag);
          check_eq("fill_data", fill_data, f.data);
        end
      end
      if (inval_we) begin
        if (exp_inval_q.size() == 0) check_eq("inval_unexp", 1, 0);
        else check_eq("inval_index", inval_index, exp_inval_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_t      f;
    logic [1:0] exp_cnt;
    int         n_inv;
    logic       done;
    logic [15:0] a;

    rst_n = 1'b0; fetch_valid = 1'b0; fetch_addr = '0; cache_hit = 1'b0;
    flush_req = 1'b0; mem_ready = 1'b0; mem_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_fill_we", fill_we, 0);
    check_eq("rst_inval_we", inval_we, 0);
    check_eq("rst_flush_done", flush_done, 0);
    check_eq("rst_miss_count", miss_count, 0);

    // Hit path
    tick();
    fetch_valid = 1'b1; cache_hit = 1'b1; fetch_addr = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hit_stall", stall, 0);
      check_eq("hit_mem_req", mem_req, 0);
    end
    check_eq("hit_miss_count", miss_count, 0);

    // Miss/refill with mem_ready four cycles after the request rises
    tick();
    fetch_addr = 16'h1236; cache_hit = 1'b0;
    exp_addr_q.push_back(16'h1234);
    f.idx = 3'd5; f.tag = 11'h091; f.data = 64'hAAAA_BBBB_CCCC_DDDD;
    exp_fill_q.push_back(f);
    @(negedge clk);
    check_eq("miss_detect_stall", stall, 1);
    wait_mem_req();
    tick(); tick(); tick();
    mem_ready = 1'b1; mem_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    mem_ready = 1'b0; mem_data = '0; cache_hit = 1'b1;
    @(negedge clk);
    check_eq("fill_stall", stall, 1);
    check_eq("fill_we_seen", fill_we, 1);
    tick();
    @(negedge clk);
    check_eq("after_fill_stall", stall, 0);
    check_eq("after_fill_mem_req", mem_req, 0);
    check_eq("miss_count_1", miss_count, 1);
    check_eq("fill_q_empty", exp_fill_q.size(), 0);

    // Flush sweep from IDLE
    tick();
    fetch_valid = 1'b0; flush_req = 1'b1;
    for (int i = 0; i < 8; i++) exp_inval_q.push_back(3'(i));
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("flush_stall", stall, 1);
      check_eq("flush_inval_we", inval_we, 1);
      check_eq("flush_done", flush_done, (i == 7) ? 1 : 0);
    end
    @(negedge clk);
    check_eq("post_flush_inval_we", inval_we, 0);
    check_eq("post_flush_stall", stall, 0);
    check_eq("inval_q_empty", exp_inval_q.size(), 0);

    // Flush requested during refill
    tick();
    fetch_valid = 1'b1; cache_hit = 1'b0; fetch_addr = 16'h2468;
    exp_addr_q.push_back(16'h2468);
    f.idx = 3'd2; f.tag = 11'h123; f.data = 64'h0123_4567_89AB_CDEF;
    exp_fill_q.push_back(f);
    wait_mem_req();
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0; mem_ready = 1'b1; mem_data = 64'h0123_4567_89AB_CDEF;
    tick();
    mem_ready = 1'b0; cache_hit = 1'b1;
    for (int i = 0; i < 8; i++) exp_inval_q.push_back(3'(i));
    n_inv = 0; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inval_we) n_inv++;
      if (flush_done) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("pend_flush_done", done, 1);
    check_eq("pend_flush_cycles", n_inv, 8);
    check_eq("pend_fill_q_empty", exp_fill_q.size(), 0);
    check_eq("miss_count_2", miss_count, 2);

    // Reset while a refill is outstanding
    tick();
    fetch_addr = 16'h0100; cache_hit = 1'b0;
    exp_addr_q.push_back(16'h0100);
    wait_mem_req();
    tick();
    rst_n = 1'b0; fetch_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstmid_mem_req", mem_req, 0);
    check_eq("rstmid_stall", stall, 0);
    check_eq("rstmid_miss_count", miss_count, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rstmid_no_fill", fill_we, 0);
    end

    // Saturating miss counter, memory answering on the first request cycle
    exp_cnt = 2'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      a = 16'h4000 + 16'(i * 4);
      fetch_valid = 1'b1; cache_hit = 1'b0; fetch_addr = a + 16'd1;
      exp_addr_q.push_back(a);
      f.idx = a[4:2]; f.tag = a[15:5]; f.data = {4{a}};
      exp_fill_q.push_back(f);
      exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
      wait_mem_req();
      mem_ready = 1'b1; mem_data = {4{a}};
      tick();
      mem_ready = 1'b0; cache_hit = 1'b1;
      tick();
      @(negedge clk);
      check_eq("sat_stall", stall, 0);
      check_eq("sat_miss_count", miss_count, exp_cnt);
    end
    check_eq("sat_fill_q_empty", exp_fill_q.size(), 0);
    check_eq("sat_addr_q_empty", exp_addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
